// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
module param_fifo #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge;
  // an empty FIFO never lets a same-cycle push fall through to data_out.
  always_comb begin
    pop_ok  = pop && !fifo_empty;
    push_ok = push && (!fifo_full || pop_ok);
  end

  // Status flags come only from the registered count.
  assign fifo_full    = (count == CW'(DEPTH));
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= push && !push_ok;
      underflow <= pop && !pop_ok;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (DATA_W=4, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
// a queue model holds expected contents; popped entries become expected data_out.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       push, pop, flush;
  logic [3:0] data_out;
  logic       fifo_full, fifo_empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] sb_q[$];
  logic [3:0] exp_dout;
  logic       exp_ov, exp_un;

  param_fifo #(.DATA_W(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
    .flush(flush), .data_out(data_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(sb_q.size()));
    chk("fifo_full", 32'(fifo_full), 32'(sb_q.size() == 8));
    chk("fifo_empty", 32'(fifo_empty), 32'(sb_q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(sb_q.size() >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(sb_q.size() <= 2));
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("underflow", 32'(underflow), 32'(exp_un));
    chk("data_out", 32'(data_out), 32'(exp_dout));
  endtask

  task automatic step(input logic p, input logic q, input logic [3:0] d, input logic f);
    int  n;
    bit  pop_ok, push_ok;
    @(negedge clk);
    push = p; pop = q; data_in = d; flush = f;
    n       = sb_q.size();
    pop_ok  = q && (n > 0);
    push_ok = p && ((n < 8) || pop_ok);
    if (f) begin
      sb_q.delete();
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end else begin
      if (pop_ok) exp_dout = sb_q.pop_front();
      if (push_ok) sb_q.push_back(d);
      exp_ov = p && !push_ok;
      exp_un = q && !pop_ok;
    end
    @(posedge clk);
    #1;
    check_all();
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_dout = '0;
    exp_ov   = 1'b0;
    exp_un   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; data_in = '0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // ordered push/pop through a partly filled FIFO
    step(1, 0, 4'd10, 0); step(1, 0, 4'd9, 0); step(1, 0, 4'd2, 0); step(1, 0, 4'd3, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'd0, 0);
    step(0, 0, 4'd0, 0);

    // fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) step(1, 0, 4'(i), 0);
    step(1, 0, 4'd15, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 4'd0, 0);

    // full with simultaneous push/pop, pointers wrap
    for (int i = 0; i < 8; i++) step(1, 0, 4'(i + 8), 0);
    for (int i = 1; i <= 10; i++) step(1, 1, 4'(i), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 4'd0, 0);

    // underflow alone, then push+pop on empty
    step(0, 1, 4'd0, 0);
    step(1, 1, 4'd5, 0);
    step(0, 1, 4'd0, 0);

    // flush with and without concurrent requests
    for (int i = 0; i < 5; i++) step(1, 0, 4'(i + 11), 0);
    step(1, 1, 4'd12, 1);
    step(0, 0, 4'd0, 0);
    step(1, 0, 4'd7, 0);
    step(0, 1, 4'd0, 0);

    // asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) step(1, 0, 4'(i + 1), 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 4'd0, 0);
    step(1, 0, 4'd6, 0);
    step(0, 1, 4'd0, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 4, data word width in bits (1..32) SHALL be supported.
REQ-002 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two, 2..256.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  DATA_W  write data, sampled on the clk edge when push is accepted.
REQ-008 push  input  1  write request, level-sampled each rising edge.
REQ-009 pop  input  1  read request, level-sampled each rising edge.
REQ-010 flush  input  1  synchronous clear of contents, priority over push/pop.
REQ-011 data_out  output  DATA_W  registered read data.
REQ-012 fifo_full  output  1  high when count == DEPTH.
REQ-013 fifo_empty  output  1  high when count == 0.
REQ-014 almost_full  output  1  high when count >= AF_LEVEL.
REQ-015 almost_empty  output  1  high when count <= AE_LEVEL.
REQ-016 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse, push rejected.
REQ-018 underflow  output  1  one-cycle pulse, pop rejected.

Function
REQ-019 Storage SHALL be a DEPTH x DATA_W register array addressed by wr_ptr/rd_ptr of width $clog2(DEPTH); pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 Push accepted when push=1 and (fifo_full=0 or pop accepted same cycle): data_in written at wr_ptr, wr_ptr+1.
REQ-021 Pop accepted when pop=1 and fifo_empty=0: mem[rd_ptr] loaded into data_out on the same edge, rd_ptr+1; read latency one cycle from pop sample.
REQ-022 data_out SHALL hold its last value when no pop is accepted.
REQ-023 count SHALL be +1 on push-only accept, -1 on pop-only accept, unchanged on both or neither.
REQ-024 Full + push + pop: both accepted, count stays DEPTH, no overflow.
REQ-025 Empty + push + pop: push accepted, pop rejected, underflow pulses, count becomes 1, data_out unchanged (no fall-through).
REQ-026 Full + push without pop: write ignored, memory and pointers unchanged, overflow=1 for that cycle.
REQ-027 Empty + pop without push: ignored, underflow=1 for that cycle.
REQ-028 All status flags (full, empty, almost_*) SHALL be registered or derived from registered count, valid the cycle after the causing edge, no combinational path from push/pop.
REQ-029 flush=1: pointers and count to 0, fifo_empty=1, push/pop that cycle ignored, no overflow/underflow pulse, data_out unchanged, memory contents need not be cleared.

Reset
REQ-030 reset=1 SHALL immediately, without clk, force wr_ptr=rd_ptr=0, count=0, data_out=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, overflow=0, underflow=0.
REQ-031 Reset mid-operation SHALL discard all stored entries; first edge after deassertion behaves as empty FIFO.
REQ-032 Memory array need not be reset.

Verification (DATA_W=4, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-033 Reset pulse, then push 10,9,2,3 on consecutive edges, then pop x4 -> data_out 10,9,2,3 each one cycle after pop sample; count 4->0; empty=1 at end.
REQ-034 Push 8 words 0..7 -> fifo_full=1 after 8th edge, almost_full from count 6; 9th push value 15 -> overflow pulse, count 8; pop x8 returns 0..7 (no 15).
REQ-035 Fill to 8, hold push=pop=1 for 10 cycles with data 1..10 -> count stays 8, full stays 1, no overflow; outputs in order, pointers wrap correctly.
REQ-036 Empty FIFO, pop=1 alone -> underflow one cycle, data_out holds; push=pop=1 with data 5 -> count 1, underflow pulse, next pop gives 5.
REQ-037 Load 5 entries, assert flush -> count 0, empty 1 next cycle; subsequent push 7, pop -> data_out 7.
REQ-038 Load 3 entries, assert reset between clock edges -> outputs at reset values immediately, before next clk edge.
